// File: rtl/lcv_alu_share_arb_if.sv
// lcv_alu_share_arb_if: requester, shared-ALU and response signals of the ALU share arbiter.
interface lcv_alu_share_arb_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [2:0]               alu_op;
    logic [WIDTH-1:0]         alu_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/lcv_alu_share_arb.sv
// lcv_alu_share_arb: round-robin sharing of one 1-cycle-latency ALU among NUM_REQ
// requesters, with results returned in issue order through a 2-entry FIFO.
module lcv_alu_share_arb #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input logic                clk,
    input logic                rst,
    lcv_alu_share_arb_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             inflight;
    logic [IDW-1:0]   inflight_id;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [1:0]       fifo_count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             found;
    logic             pop;
    logic             can_issue;
    logic             issue;
    logic [2:0]       pending;
    logic [IDW-1:0]   fifo_id [2];
    logic [WIDTH-1:0] fifo_data [2];

    // Counting the in-flight result as already buffered keeps the FIFO from overflowing.
    assign pop       = bus.rsp_valid & bus.rsp_ready;
    assign pending   = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign can_issue = !rst && pending < 3'd2;
    assign issue     = can_issue & found;

    always_comb begin
        ptr   = last_grant;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ptr = (ptr == IDW'(NUM_REQ - 1)) ? '0 : ptr + IDW'(1);
            if (!found && bus.req_valid[ptr]) begin
                found = 1'b1;
                win   = ptr;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (issue) bus.req_ready[win] = 1'b1;
    end

    assign bus.alu_a     = issue ? bus.req_a[int'(win)*WIDTH +: WIDTH] : '0;
    assign bus.alu_b     = issue ? bus.req_b[int'(win)*WIDTH +: WIDTH] : '0;
    assign bus.alu_op    = issue ? bus.req_op[int'(win)*3 +: 3] : '0;
    assign bus.rsp_valid = !rst && fifo_count != 2'd0;
    assign bus.rsp_id    = bus.rsp_valid ? fifo_id[rd_ptr] : '0;
    assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_id <= '0;
            last_grant  <= IDW'(NUM_REQ - 1);
            fifo_count  <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_id <= win;
                last_grant  <= win;
            end
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_id[wr_ptr]   <= inflight_id;
            fifo_data[wr_ptr] <= bus.alu_result;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(inflight && fifo_count == 2'd2));
endmodule

// File: tb/tb_lcv_alu_share_arb.sv
// tb_lcv_alu_share_arb: random and directed traffic checked every cycle against a
// transaction-queue model of the arbiter.
module tb_lcv_alu_share_arb;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        int         age;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   lg = N - 1;
    ent_t pend[$];
    logic [N*W-1:0] ra = '0;
    logic [N*W-1:0] rb = '0;
    logic [N*3-1:0] rop = '0;

    lcv_alu_share_arb_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
    lcv_alu_share_arb #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    // Shared ALU: registered result, one cycle after the operands are presented.
    always_ff @(posedge clk) bus.alu_result <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            ra[i*W +: W] = $urandom;
            rb[i*W +: W] = $urandom;
            rop[i*3 +: 3] = 3'($urandom);
        end
    endtask

    // One clock: drive, check outputs at negedge against the model, advance the model.
    task automatic step(logic r, logic [N-1:0] v, logic rr);
        logic [N-1:0] ex_rdy;
        logic [W-1:0] ex_a;
        logic [W-1:0] ex_b;
        logic [2:0]   ex_op;
        logic         vis;
        logic         pop_m;
        int           win;
        ex_rdy = '0;
        ex_a = '0;
        ex_b = '0;
        ex_op = '0;
        win = -1;
        rst = r;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        bus.req_a = ra;
        bus.req_b = rb;
        bus.req_op = rop;
        @(negedge clk);
        vis = !r && pend.size() > 0 && pend[0].age >= 2;
        pop_m = vis && rr;
        if (!r && pend.size() - int'(pop_m) < 2)
            for (int k = 1; k <= N; k++)
                if (win < 0 && v[(lg + k) % N]) win = (lg + k) % N;
        if (win >= 0) begin
            ex_rdy[win] = 1'b1;
            ex_a = ra[win*W +: W];
            ex_b = rb[win*W +: W];
            ex_op = rop[win*3 +: 3];
        end
        chk("req_ready", 64'(bus.req_ready), 64'(ex_rdy));
        chk("alu_a", 64'(bus.alu_a), 64'(ex_a));
        chk("alu_b", 64'(bus.alu_b), 64'(ex_b));
        chk("alu_op", 64'(bus.alu_op), 64'(ex_op));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(vis));
        chk("rsp_id", 64'(bus.rsp_id), vis ? 64'(pend[0].id) : 64'd0);
        chk("rsp_data", 64'(bus.rsp_data), vis ? 64'(pend[0].data) : 64'd0);
        if (r) begin
            pend.delete();
            lg = N - 1;
        end else begin
            foreach (pend[i]) pend[i].age++;
            if (pop_m) void'(pend.pop_front());
            if (win >= 0) begin
                pend.push_back('{win, alu_fn(ex_a, ex_b, ex_op), 1});
                lg = win;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        repeat (3) step(1'b1, '0, 1'b0);
        ra[W-1:0] = 5;
        rb[W-1:0] = 3;
        rop[2:0] = 3'd0;
        step(1'b0, 4'b0001, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            rop = {N{3'd1}};
            step(1'b0, 4'b1111, 1'b1);
        end
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step(1'b0, 4'b1111, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(1'b0, 4'b1111, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step(1'b0, 4'b1010, 1'b1);
        end
        repeat (3) step(1'b0, 4'b0000, 1'b1);
        rand_ops();
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        rand_ops();
        step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 800; i++) begin
            rand_ops();
            step($urandom_range(0, 99) == 0, 4'($urandom),
                 (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcv_alu_share_arb.md
LCV_ALU_SHARE_ARB -- requirements
Module: lcv_alu_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters; IDW = max(1, clog2(NUM_REQ)).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; a request transfers when both bits are high.
REQ-008 req_a, req_b  input  NUM_REQ*WIDTH each  operands; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-009 req_op  input  NUM_REQ*3  ALU op code; requester i occupies [i*3 +: 3].
REQ-010 alu_a, alu_b  output  WIDTH each  operands to the shared 1-cycle-latency ALU.
REQ-011 alu_op  output  3  op code to the shared ALU.
REQ-012 alu_result  input  WIDTH  ALU registered result, valid exactly 1 cycle after issue.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accept; a response transfers when rsp_valid and rsp_ready are both high.
REQ-015 rsp_id  output  IDW  index of the requester that owns the response.
REQ-016 rsp_data  output  WIDTH  result for that requester.

Function
REQ-017 Issue: in one cycle, at most one req_ready bit SHALL be high, only for the granted requester, and only when can_issue is true.
REQ-018 can_issue SHALL be (fifo_count + inflight - pop) < 2, with pop = rsp_valid & rsp_ready.
REQ-019 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo NUM_REQ; the first requester with valid high wins.
REQ-020 last_grant SHALL update to the winner only on a cycle in which an issue occurs.
REQ-021 In the issue cycle, alu_a, alu_b and alu_op SHALL be the winner's req_a, req_b and req_op slices; in all other cycles they SHALL be 0.
REQ-022 Issue cycle: inflight SHALL be set to 1 on the next edge and the winner index SHALL be held in inflight_id; inflight SHALL clear on the next edge if no new issue occurs.
REQ-023 When inflight=1, alu_result and inflight_id SHALL be pushed into a 2-entry output FIFO at the end of that cycle.
REQ-024 Latency: issue at cycle N SHALL make rsp_valid high at cycle N+2 if the FIFO was empty or is being drained.
REQ-025 The output FIFO SHALL be first-in first-out; rsp_valid = (fifo_count != 0); rsp_id and rsp_data SHALL show the head entry.
REQ-026 rsp_id and rsp_data SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-028 The FIFO SHALL never overflow; REQ-018 guarantees this, and an internal assertion SHALL flag a push while full.
REQ-029 Throughput SHALL be 1 issue per cycle while rsp_ready=1 and some request is pending.
REQ-030 When rsp_ready is held at 0, at most 2 issues SHALL occur before req_ready goes all-zero.
REQ-031 Op codes SHALL pass through unmodified; the block does not interpret op semantics.
REQ-032 req_ready SHALL be a function of current state and req_valid only; it SHALL NOT depend combinationally on rsp_ready beyond the pop term in REQ-018.

Reset
REQ-033 When rst is high at a clock edge, the block SHALL clear inflight, fifo_count, FIFO pointers and inflight_id.
REQ-034 When rst is high at a clock edge, the block SHALL set last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-035 During and after reset: rsp_valid=0, req_ready=0 while rst=1, alu_* = 0, rsp_id=0, rsp_data=0.
REQ-036 On reset mid-operation, in-flight and buffered results SHALL be discarded with no response emitted.

Verification
REQ-037 Single request: req_valid=0001, a=5, b=3, op=0, rsp_ready=1 -> req_ready=0001 at cycle N; rsp_valid at N+2 with rsp_id=0 and rsp_data=8.
REQ-038 All requesters request continuously with op=1 and rsp_ready=1 -> grant order 0,1,2,3,0,... with one rsp per cycle; rsp_id follows the same order.
REQ-039 rsp_ready=0 with all requesting -> exactly 2 issues (ids 0 and 1), then req_ready=0000 and rsp stable at id 0; releasing rsp_ready -> id 0 then id 1 drain, and issue resumes at id 2.
REQ-040 Sparse requests: requesters 1 and 3 only, with req_valid=1010 -> alternating grants 1,3,1,3; requesters 0 and 2 never granted.
REQ-041 Simultaneous push and pop with count=1 -> count stays 1; data order matches issue order (checked with a scoreboard against an ALU reference model).
REQ-042 Assert rst one cycle after an issue with FIFO holding 1 entry -> next cycle rsp_valid=0 with no stale response; first post-reset grant goes to requester 0.
